// File: rtl/fft_pkg.sv
// Shared definitions for the FFT magnitude path: default sizes, the peak
// tracker state enum and an index-width helper.
package fft_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_BINS_DEF = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Index width for n bins; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_peak_tracker.sv
// Streaming peak detector: one bin magnitude per beat, running max/index,
// registered frame result presented with a valid/ready handshake.
module fft_peak_tracker
    import fft_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_BINS   = NUM_BINS_DEF,
    parameter int IDX_W      = idx_width(NUM_BINS),
    parameter int TARGET_BIN = NUM_BINS - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [DATA_W-1:0] thr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_target_hit,
    output logic              out_above_thr,
    output logic              out_len_err
);

    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NUM_BINS - 1);
    localparam logic [IDX_W-1:0] TGT_BIN  = IDX_W'(TARGET_BIN);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   res_max_q, res_max_d;
    logic [IDX_W-1:0]    res_idx_q, res_idx_d;
    logic                res_hit_q, res_hit_d;
    logic                res_above_q, res_above_d;
    logic                res_err_q, res_err_d;

    logic                accept;
    logic                close;
    logic [DATA_W-1:0]   cand_max;
    logic [IDX_W-1:0]    cand_idx;

    // Ready comes from registered state only; rst gating keeps it low during reset.
    assign in_ready  = (state_q == ACCUM) && !rst;
    assign accept    = in_valid && in_ready;
    assign close     = accept && (in_last || (cnt_q == LAST_BIN));

    assign out_valid      = (state_q == HOLD);
    assign out_max        = res_max_q;
    assign out_idx        = res_idx_q;
    assign out_target_hit = res_hit_q;
    assign out_above_thr  = res_above_q;
    assign out_len_err    = res_err_q;

    // Compare-and-select: first beat seeds the max, later beats replace on strict greater.
    always_comb begin
        cand_max = max_q;
        cand_idx = idx_q;
        if ((cnt_q == '0) || (in_data > max_q)) begin
            cand_max = in_data;
            cand_idx = cnt_q;
        end
    end

    // Next-state: accumulate beats, latch the result on frame close, release on handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        idx_d       = idx_q;
        res_max_d   = res_max_q;
        res_idx_d   = res_idx_q;
        res_hit_d   = res_hit_q;
        res_above_d = res_above_q;
        res_err_d   = res_err_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    max_d = cand_max;
                    idx_d = cand_idx;
                    cnt_d = cnt_q + IDX_W'(1);
                    if (close) begin
                        cnt_d       = '0;
                        res_max_d   = cand_max;
                        res_idx_d   = cand_idx;
                        res_hit_d   = (cand_idx == TGT_BIN);
                        res_above_d = (cand_max >= thr);
                        res_err_d   = !(in_last && (cnt_q == LAST_BIN));
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            res_max_q   <= '0;
            res_idx_q   <= '0;
            res_hit_q   <= 1'b0;
            res_above_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            res_max_q   <= res_max_d;
            res_idx_q   <= res_idx_d;
            res_hit_q   <= res_hit_d;
            res_above_q <= res_above_d;
            res_err_q   <= res_err_d;
        end
    end

endmodule
